// File: rtl/pixel_array_pkg.sv
// Shared geometry and per-pixel integration gain for the pixel array.
package PixelSensorConfig;

    localparam int PIXEL_ARRAY_HEIGHT = 2;
    localparam int PIXEL_ARRAY_WIDTH  = 2;

    // Exposure gain cycles 1..4 across the raster order of the array.
    function automatic logic [7:0] pixel_inc(input int r, input int c, input int width);
        return 8'(1 + ((r * width + c) % 4));
    endfunction

endpackage

// File: rtl/pixel_array_sensor.sv
// One pixel: saturating integrator, ramp counter and single-shot comparator latch.
module pixel_sensor (
    input  logic       clk,
    input  logic       reset,
    input  logic       VBN1,
    input  logic       RAMP,
    input  logic       ERASE,
    input  logic       EXPOSE,
    input  logic [7:0] COUNTER,
    input  logic [7:0] INC,
    output logic [7:0] M
);

    logic [7:0] level;
    logic [7:0] ramp_v;
    logic       tripped;
    logic       vbn1_q;
    logic       ramp_q;
    logic       vbn1_rise;
    logic       ramp_rise;

    assign vbn1_rise = VBN1 & ~vbn1_q;
    assign ramp_rise = RAMP & ~ramp_q;

    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[8] ? 8'hff : sum[7:0];
    endfunction

    // The comparator is armed only outside exposure, so a freshly erased
    // pixel (L=0, V=0) does not trip before it has integrated anything.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level   <= '0;
            ramp_v  <= '0;
            tripped <= 1'b0;
            M       <= '0;
            vbn1_q  <= 1'b0;
            ramp_q  <= 1'b0;
        end else begin
            vbn1_q <= VBN1;
            ramp_q <= RAMP;
            if (ERASE) begin
                level   <= '0;
                ramp_v  <= '0;
                tripped <= 1'b0;
                M       <= '0;
            end else begin
                if (EXPOSE && vbn1_rise)
                    level <= sat_add(level, INC);
                if (!EXPOSE && ramp_rise && ramp_v != 8'hff)
                    ramp_v <= ramp_v + 8'd1;
                if (!EXPOSE && !tripped && ramp_v >= level) begin
                    tripped <= 1'b1;
                    M       <= COUNTER;
                end
            end
        end
    end

endmodule

// File: rtl/pixel_array.sv
// Pixel array: grid of pixel_sensor instances with a one-hot row readout bus.
module pixel_array #(
    parameter int PIXEL_ARRAY_HEIGHT = PixelSensorConfig::PIXEL_ARRAY_HEIGHT,
    parameter int PIXEL_ARRAY_WIDTH  = PixelSensorConfig::PIXEL_ARRAY_WIDTH
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             VBN1,
    input  logic                             RAMP,
    input  logic                             ERASE,
    input  logic                             EXPOSE,
    input  logic [PIXEL_ARRAY_HEIGHT-1:0]    READ,
    input  logic [7:0]                       COUNTER,
    output logic [PIXEL_ARRAY_WIDTH*8-1:0]   DATA_OUT
);

    import PixelSensorConfig::pixel_inc;

    logic [7:0]                     mem [PIXEL_ARRAY_HEIGHT][PIXEL_ARRAY_WIDTH];
    logic [PIXEL_ARRAY_WIDTH*8-1:0] row_data;
    logic                           row_hit;

    for (genvar r = 0; r < PIXEL_ARRAY_HEIGHT; r++) begin : g_row
        for (genvar c = 0; c < PIXEL_ARRAY_WIDTH; c++) begin : g_col
            localparam logic [7:0] INC_RC = pixel_inc(r, c, PIXEL_ARRAY_WIDTH);
            pixel_sensor u_pixel (
                .clk     (clk),
                .reset   (reset),
                .VBN1    (VBN1),
                .RAMP    (RAMP),
                .ERASE   (ERASE),
                .EXPOSE  (EXPOSE),
                .COUNTER (COUNTER),
                .INC     (INC_RC),
                .M       (mem[r][c])
            );
        end
    end

    // Scan from the top row down so the lowest selected row is the one left standing.
    always_comb begin
        row_data = '0;
        row_hit  = 1'b0;
        for (int r = PIXEL_ARRAY_HEIGHT - 1; r >= 0; r--) begin
            if (READ[r]) begin
                row_hit = 1'b1;
                for (int c = 0; c < PIXEL_ARRAY_WIDTH; c++)
                    row_data[c*8 +: 8] = mem[r][c];
            end
        end
    end

    assign DATA_OUT = row_hit ? row_data : {(PIXEL_ARRAY_WIDTH*8){1'bz}};

endmodule

// File: tb/tb_pixel_array.sv
// Directed bench for pixel_array; a released bus reads as all ones via pull-ups.
module tb_pixel_array;

    logic        clk = 1'b0;
    logic        reset;
    logic        VBN1;
    logic        RAMP;
    logic        ERASE;
    logic        EXPOSE;
    logic [1:0]  READ;
    logic [7:0]  COUNTER;
    wire  [15:0] data_out;

    int total = 0;
    int bad   = 0;

    for (genvar i = 0; i < 16; i++) begin : g_pu
        pullup (data_out[i]);
    end

    pixel_array #(.PIXEL_ARRAY_HEIGHT(2), .PIXEL_ARRAY_WIDTH(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .VBN1     (VBN1),
        .RAMP     (RAMP),
        .ERASE    (ERASE),
        .EXPOSE   (EXPOSE),
        .READ     (READ),
        .COUNTER  (COUNTER),
        .DATA_OUT (data_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        total++;
        assert (obs === exp_v)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic read_row(input string tag, input logic [1:0] sel, input logic [15:0] exp_v);
        READ = sel;
        #1;
        check(tag, data_out, exp_v);
        READ = 2'b00;
        #1;
    endtask

    task automatic erase_frame();
        ERASE  = 1'b1;
        EXPOSE = 1'b0;
        repeat (5) @(negedge clk);
        ERASE  = 1'b0;
        EXPOSE = 1'b1;
    endtask

    task automatic vbn1_ticks(input int n);
        repeat (n) begin
            VBN1 = 1'b1;
            @(negedge clk);
            VBN1 = 1'b0;
            @(negedge clk);
        end
    endtask

    // Each ramp step presents COUNTER=k while the ramp value equals k.
    task automatic convert(input int last);
        EXPOSE = 1'b0;
        for (int k = 0; k <= last; k++) begin
            COUNTER = 8'(k);
            RAMP    = 1'b0;
            @(negedge clk);
            RAMP    = 1'b1;
            @(negedge clk);
        end
        RAMP = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        VBN1    = 1'b0;
        RAMP    = 1'b0;
        ERASE   = 1'b0;
        EXPOSE  = 1'b0;
        READ    = 2'b00;
        COUNTER = 8'd0;
        repeat (2) @(negedge clk);

        read_row("rst_row0", 2'b01, 16'h0000);
        read_row("rst_row1", 2'b10, 16'h0000);
        read_row("rst_idle", 2'b00, 16'hffff);
        ERASE = 1'b1;
        @(negedge clk);
        reset = 1'b0;

        // Frame A: 10 ticks -> 10/20/30/40
        erase_frame();
        vbn1_ticks(10);
        convert(255);
        read_row("a_row0", 2'b01, 16'h140a);
        read_row("a_row1", 2'b10, 16'h281e);
        read_row("a_both", 2'b11, 16'h140a);
        read_row("a_idle", 2'b00, 16'hffff);
        read_row("a_row0_reread", 2'b01, 16'h140a);
        COUNTER = 8'd77;
        RAMP    = 1'b1;
        repeat (3) @(negedge clk);
        RAMP    = 1'b0;
        read_row("a_row0_hold", 2'b01, 16'h140a);

        // Frame B: 100 ticks -> 100, 200, saturated 255, 255
        erase_frame();
        vbn1_ticks(100);
        convert(255);
        read_row("b_row0", 2'b01, 16'hc864);
        read_row("b_row1", 2'b10, 16'hffff);

        // Frame C: no exposure -> everything latches COUNTER=0 at once
        erase_frame();
        EXPOSE  = 1'b0;
        COUNTER = 8'd0;
        vbn1_ticks(5);
        COUNTER = 8'd99;
        repeat (3) @(negedge clk);
        read_row("c_row0", 2'b01, 16'h0000);
        read_row("c_row1", 2'b10, 16'h0000);

        // Frame D: reset after row 0 has tripped
        erase_frame();
        vbn1_ticks(10);
        convert(25);
        read_row("d_row0_pre", 2'b01, 16'h140a);
        read_row("d_row1_pre", 2'b10, 16'h0000);
        #2;
        reset = 1'b1;
        #1;
        read_row("d_rst_row0", 2'b01, 16'h0000);
        read_row("d_rst_both", 2'b11, 16'h0000);
        read_row("d_rst_row1", 2'b10, 16'h0000);
        read_row("d_rst_idle", 2'b00, 16'hffff);
        RAMP    = 1'b0;
        COUNTER = 8'd0;
        ERASE   = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Frame E: ticks under ERASE+EXPOSE and with EXPOSE=0 are ignored
        ERASE  = 1'b1;
        EXPOSE = 1'b1;
        vbn1_ticks(2);
        erase_frame();
        vbn1_ticks(5);
        EXPOSE = 1'b0;
        vbn1_ticks(3);
        convert(255);
        read_row("e_row0", 2'b01, 16'h0a05);
        read_row("e_row1", 2'b10, 16'h140f);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
